seg7_scan_capture: RTL and testbench

- Receive-side counterpart of the team's hex-to-7-segment encoder.
- Monitors a time-multiplexed, active-low 7-segment display bus (segment lines plus per-digit anode enables).
- Waits for each digit's pattern to be stable, then reverse-decodes it to a hex nibble and assembles the digits into a frame word.
- Delivers the frame over a valid/ready handshake. Used for on-chip display loopback checking and self-test of the display path.

---
 rtl/seg7_scan_capture.sv | 137 +++++++++++++
 tb/tb_seg7_scan_capture.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_capture.sv
// Receive side of the 7-segment display path: samples a multiplexed active-low
// segment/anode bus, reverse-decodes each stable digit and delivers whole frames.
module seg7_scan_capture #(
  parameter int NDIG       = 4,
  parameter int STABLE_CYC = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [6:0]          seg_n,
  input  logic [NDIG-1:0]     an_n,
  output logic [4*NDIG-1:0]   frame_data,
  output logic [NDIG-1:0]     frame_amb,
  output logic [NDIG-1:0]     frame_err,
  output logic                frame_valid,
  input  logic                frame_ready,
  output logic                overrun
);

  localparam logic [3:0] STABLE_MAX = 4'(STABLE_CYC);

  // Reverse decode of {g..a}; result is {amb, err, nibble}.
  function automatic logic [5:0] seg_decode(input logic [6:0] pat);
    case (pat)
      7'h40:   seg_decode = 6'b10_0000;
      7'h79:   seg_decode = 6'b00_0001;
      7'h24:   seg_decode = 6'b00_0010;
      7'h30:   seg_decode = 6'b00_0011;
      7'h19:   seg_decode = 6'b00_0100;
      7'h12:   seg_decode = 6'b00_0101;
      7'h02:   seg_decode = 6'b00_0110;
      7'h78:   seg_decode = 6'b00_0111;
      7'h00:   seg_decode = 6'b10_1000;
      7'h10:   seg_decode = 6'b00_1001;
      7'h08:   seg_decode = 6'b00_1010;
      7'h01:   seg_decode = 6'b00_1011;
      7'h21:   seg_decode = 6'b00_1101;
      default: seg_decode = 6'b01_0000;
    endcase
  endfunction

  logic [NDIG+6:0]   smp_r, prv_r;
  logic [3:0]        cnt_r, cnt_s;
  logic [NDIG-1:0]   mask_r, mask_s;
  logic [4*NDIG-1:0] sh_data_r, sh_data_s;
  logic [NDIG-1:0]   sh_amb_r, sh_amb_s, sh_err_r, sh_err_s;
  logic [NDIG-1:0]   sel_s;
  logic [3:0]        low_cnt_s;
  logic              selecting_s, same_s, capture_s, complete_s, can_load_s;
  logic [5:0]        dec_s;

  // Digit select, stability tracking, shadow update and frame-completion detect.
  always_comb begin
    sel_s     = ~smp_r[NDIG+6:7];
    low_cnt_s = 4'd0;
    for (int i = 0; i < NDIG; i++) begin
      if (sel_s[i]) begin
        low_cnt_s = low_cnt_s + 4'd1;
      end else begin
        low_cnt_s = low_cnt_s;
      end
    end
    selecting_s = (low_cnt_s == 4'd1);
    same_s      = (smp_r == prv_r);

    if (!selecting_s) begin
      cnt_s = 4'd0;
    end else if (!same_s) begin
      cnt_s = 4'd1;
    end else if (cnt_r == STABLE_MAX) begin
      cnt_s = cnt_r;
    end else begin
      cnt_s = cnt_r + 4'd1;
    end
    // A changed sample always restarts the count, so STABLE_CYC=1 still captures on change.
    capture_s = selecting_s && (cnt_s == STABLE_MAX) && (!same_s || (cnt_r != STABLE_MAX));

    dec_s     = seg_decode(smp_r[6:0]);
    sh_data_s = sh_data_r;
    sh_amb_s  = sh_amb_r;
    sh_err_s  = sh_err_r;
    mask_s    = mask_r;
    for (int i = 0; i < NDIG; i++) begin
      if (capture_s && sel_s[i]) begin
        sh_data_s[4*i +: 4] = dec_s[3:0];
        sh_amb_s[i]         = dec_s[5];
        sh_err_s[i]         = dec_s[4];
        mask_s[i]           = 1'b1;
      end else begin
        mask_s[i]           = mask_s[i];
      end
    end
    complete_s = capture_s && (mask_s == {NDIG{1'b1}});
    can_load_s = !frame_valid || frame_ready;
  end

  // Input register, capture state and output frame/handshake registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      smp_r       <= '0;
      prv_r       <= '0;
      cnt_r       <= 4'd0;
      mask_r      <= '0;
      sh_data_r   <= '0;
      sh_amb_r    <= '0;
      sh_err_r    <= '0;
      frame_data  <= '0;
      frame_amb   <= '0;
      frame_err   <= '0;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      smp_r     <= {an_n, seg_n};
      prv_r     <= smp_r;
      cnt_r     <= cnt_s;
      sh_data_r <= sh_data_s;
      sh_amb_r  <= sh_amb_s;
      sh_err_r  <= sh_err_s;
      mask_r    <= complete_s ? '0 : mask_s;
      if (complete_s && can_load_s) begin
        frame_data  <= sh_data_s;
        frame_amb   <= sh_amb_s;
        frame_err   <= sh_err_s;
        frame_valid <= 1'b1;
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end else begin
        frame_valid <= frame_valid;
      end
      if (complete_s && !can_load_s) begin
        overrun <= 1'b1;
      end else begin
        overrun <= overrun;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture: table of full frames plus hand-written
// sequences for short holds, overrun, invalid anode patterns and mid-frame reset.
module tb_seg7_scan_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;
  logic [15:0] frame_data;
  logic [3:0]  frame_amb, frame_err;
  logic        frame_valid, frame_ready, overrun;

  int n_tests = 0;
  int n_fail  = 0;
  int vcount  = 0;

  seg7_scan_capture #(.NDIG(4), .STABLE_CYC(3)) dut (
    .clk(clk), .rst(rst), .seg_n(seg_n), .an_n(an_n),
    .frame_data(frame_data), .frame_amb(frame_amb), .frame_err(frame_err),
    .frame_valid(frame_valid), .frame_ready(frame_ready), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  p0, p1, p2, p3;
    logic [15:0] exp_data;
    logic [3:0]  exp_amb, exp_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic show(input int d, input logic [6:0] p, input int n);
    an_n  = ~(4'b0001 << d);
    seg_n = p;
    repeat (n) begin
      @(negedge clk);
      if (frame_valid) vcount++;
    end
  endtask

  task automatic blank(input int n);
    an_n  = 4'hF;
    seg_n = 7'h7F;
    repeat (n) begin
      @(negedge clk);
      if (frame_valid) vcount++;
    end
  endtask

  task automatic scan_frame(input logic [6:0] a, input logic [6:0] b,
                            input logic [6:0] c, input logic [6:0] d);
    show(0, a, 4);
    show(1, b, 4);
    show(2, c, 4);
    show(3, d, 4);
    blank(2);
  endtask

  task automatic wait_valid(input string name);
    int k = 0;
    while (!frame_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check(name, {31'd0, frame_valid}, 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    an_n = 4'hF;
    seg_n = 7'h7F;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic accept();
    frame_ready = 1'b1;
    @(negedge clk);
    check("valid_drop_after_accept", {31'd0, frame_valid}, 32'd0);
    frame_ready = 1'b0;
  endtask

  vec_t vecs [5];

  initial begin
    vecs[0] = '{7'h79, 7'h24, 7'h30, 7'h19, 16'h4321, 4'b0000, 4'b0000};
    vecs[1] = '{7'h40, 7'h00, 7'h7F, 7'h19, 16'h4080, 4'b0011, 4'b0100};
    vecs[2] = '{7'h12, 7'h02, 7'h78, 7'h10, 16'h9765, 4'b0000, 4'b0000};
    vecs[3] = '{7'h08, 7'h01, 7'h21, 7'h00, 16'h8DBA, 4'b1000, 4'b0000};
    vecs[4] = '{7'h40, 7'h40, 7'h40, 7'h40, 16'h0000, 4'b1111, 4'b0000};

    frame_ready = 1'b0;
    @(negedge clk);
    do_reset();
    check("reset_data",    {16'd0, frame_data}, 32'd0);
    check("reset_amb",     {28'd0, frame_amb}, 32'd0);
    check("reset_err",     {28'd0, frame_err}, 32'd0);
    check("reset_valid",   {31'd0, frame_valid}, 32'd0);
    check("reset_overrun", {31'd0, overrun}, 32'd0);

    // Table of full frames, consumer stalled until each frame is inspected.
    for (int i = 0; i < 5; i++) begin
      scan_frame(vecs[i].p0, vecs[i].p1, vecs[i].p2, vecs[i].p3);
      wait_valid($sformatf("vec%0d_valid", i));
      check($sformatf("vec%0d_data", i), {16'd0, frame_data}, {16'd0, vecs[i].exp_data});
      check($sformatf("vec%0d_amb", i),  {28'd0, frame_amb},  {28'd0, vecs[i].exp_amb});
      check($sformatf("vec%0d_err", i),  {28'd0, frame_err},  {28'd0, vecs[i].exp_err});
      accept();
    end
    check("table_no_overrun", {31'd0, overrun}, 32'd0);

    // Ready held high: exactly one valid cycle per frame.
    frame_ready = 1'b1;
    vcount = 0;
    scan_frame(7'h79, 7'h24, 7'h30, 7'h19);
    blank(8);
    check("pulse_count", vcount, 32'd1);
    check("pulse_data", {16'd0, frame_data}, 32'h4321);
    frame_ready = 1'b0;

    // Digit 1 held only two cycles: no frame until it is held three.
    show(0, 7'h79, 4);
    show(1, 7'h24, 2);
    show(2, 7'h30, 4);
    show(3, 7'h19, 4);
    blank(10);
    check("short_hold_no_valid", {31'd0, frame_valid}, 32'd0);
    show(1, 7'h24, 3);
    blank(2);
    wait_valid("short_hold_then_valid");
    check("short_hold_data", {16'd0, frame_data}, 32'h4321);
    accept();

    // Overrun: second frame dropped while first is stalled.
    scan_frame(7'h79, 7'h24, 7'h30, 7'h19);
    wait_valid("ovr_first_valid");
    check("ovr_not_yet", {31'd0, overrun}, 32'd0);
    scan_frame(7'h12, 7'h02, 7'h78, 7'h10);
    check("ovr_set", {31'd0, overrun}, 32'd1);
    check("ovr_held_data", {16'd0, frame_data}, 32'h4321);
    check("ovr_still_valid", {31'd0, frame_valid}, 32'd1);
    accept();
    check("ovr_sticky", {31'd0, overrun}, 32'd1);

    // Multi-select and blanking must neither capture nor disturb the mask.
    do_reset();
    check("rst_clears_overrun", {31'd0, overrun}, 32'd0);
    show(0, 7'h12, 4);
    show(1, 7'h02, 4);
    show(2, 7'h78, 4);
    an_n = 4'b0011;
    seg_n = 7'h10;
    repeat (10) @(negedge clk);
    blank(10);
    check("multisel_no_valid", {31'd0, frame_valid}, 32'd0);
    show(3, 7'h10, 4);
    blank(2);
    wait_valid("multisel_valid");
    check("multisel_data", {16'd0, frame_data}, 32'h9765);
    accept();

    // Reset after three captures: no residue in the following frame.
    show(0, 7'h79, 4);
    show(1, 7'h24, 4);
    show(2, 7'h30, 4);
    do_reset();
    show(0, 7'h12, 4);
    show(1, 7'h02, 4);
    show(2, 7'h78, 4);
    blank(4);
    check("rst_mid_no_early_valid", {31'd0, frame_valid}, 32'd0);
    show(3, 7'h10, 4);
    blank(2);
    wait_valid("rst_mid_valid");
    check("rst_mid_data", {16'd0, frame_data}, 32'h9765);
    check("rst_mid_amb", {28'd0, frame_amb}, 32'd0);
    check("rst_mid_err", {28'd0, frame_err}, 32'd0);
    accept();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
